// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a shared bank of transparent latches.
// Latency: req sampled in IDLE at T -> lat_en high T+2..T+1+OPEN_CYC, gnt at T+2+OPEN_CYC.
// Backpressure: requesters hold req until their one-cycle gnt; req is ignored while busy.
module latch_bank_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DW-1:0]    wdata,
  input  logic [NREQ*AW-1:0]    waddr,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [DW-1:0]         lat_d,
  output logic [(1<<AW)-1:0]    lat_en
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam int NW = 1 << AW;

  localparam logic [NW-1:0]   EN_ONE  = NW'(1);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  // One-hot state encoding so every output decodes from a single flop.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SETUP = 4'b0010,
    S_OPEN  = 4'b0100,
    S_HOLD  = 4'b1000
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;      // last winner; search starts one past it
  logic [PW-1:0] win;
  logic [PW-1:0] win_r;
  logic [AW-1:0] addr_r;
  logic [CW-1:0] cnt;

  // Round-robin pick: first set req bit at or after ptr+1, wrapping at NREQ.
  always_comb begin
    logic found;
    int   idx;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Write sequencer: capture, setup, enable pulse, hold/grant; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= PW'(NREQ - 1);
      win_r  <= '0;
      addr_r <= '0;
      cnt    <= '0;
      lat_d  <= '0;
      lat_en <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            win_r  <= win;
            addr_r <= waddr[int'(win)*AW +: AW];
            lat_d  <= wdata[int'(win)*DW +: DW];
            busy   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Data has been stable a full cycle before the enable rises.
          lat_en <= EN_ONE << addr_r;
          cnt    <= CW'(OPEN_CYC - 1);
          state  <= S_OPEN;
        end
        S_OPEN: begin
          if (cnt == '0) begin
            lat_en <= '0;
            gnt    <= GNT_ONE << win_r;
            state  <= S_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          // lat_d stays put this cycle so the latch closes on stable data.
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= win_r;
          state <= S_IDLE;
        end
        default: begin
          lat_en <= '0;
          gnt    <= '0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
